// File: rtl/piece_move_scheduler_pkg.sv
// piece_move_scheduler_pkg: move command encodings and scheduler FSM state codes
package piece_move_scheduler_pkg;
   typedef logic [1:0] cmd_t;
   localparam cmd_t CMD_LEFT  = 2'd0;
   localparam cmd_t CMD_RIGHT = 2'd1;
   localparam cmd_t CMD_DOWN  = 2'd2;
   localparam cmd_t CMD_LOCK  = 2'd3;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_WAIT = 3'd1;
   localparam logic [2:0] ST_DROP = 3'd2;
   localparam logic [2:0] ST_LOCK = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;
endpackage

// File: rtl/piece_move_scheduler_if.sv
// piece_move_scheduler_if: req/ack move command channel between scheduler and board datapath
interface piece_move_scheduler_if;
   import piece_move_scheduler_pkg::*;
   logic move_req;
   cmd_t move_cmd;
   logic move_ack;
   logic move_ok;
   modport master (output move_req, move_cmd, input move_ack, move_ok);
   modport slave (input move_req, move_cmd, output move_ack, move_ok);
endinterface

// File: rtl/piece_move_scheduler_key_autorepeat.sv
// piece_move_scheduler_key_autorepeat: key edge detect plus DAS auto-repeat, one set pulse per move
module piece_move_scheduler_key_autorepeat #(
   parameter int DAS_DELAY  = 12_500_000,
   parameter int DAS_REPEAT = 2_500_000,
   parameter int CNT_W      = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic key_i,
   output logic set_o
);
   logic             key_q;
   logic             rep_q, rep_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             held, hit;
   assign held  = en_i & key_i & key_q;
   assign hit   = cnt_q == (rep_q ? CNT_W'(DAS_REPEAT - 1) : CNT_W'(DAS_DELAY - 1));
   assign set_o = en_i & key_i & (~key_q | hit);
   assign cnt_d = (held & ~hit) ? cnt_q + CNT_W'(1) : '0;
   assign rep_d = held & (rep_q | hit);
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= 1'b0;
         rep_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         key_q <= key_i;
         rep_q <= rep_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/piece_move_scheduler.sv
// piece_move_scheduler: merges keys and gravity into one serialized move command stream,
// turning a failed DOWN into a LOCK and pulsing piece_locked once the lock is accepted.
module piece_move_scheduler
   import piece_move_scheduler_pkg::*;
#(
   parameter int GRAVITY_TICKS = 50_000_000,
   parameter int DAS_DELAY     = 12_500_000,
   parameter int DAS_REPEAT    = 2_500_000,
   parameter int CNT_W         = 27
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          game_en,
   input  logic                          key_left,
   input  logic                          key_right,
   input  logic                          key_drop,
   piece_move_scheduler_if.master        bus,
   output logic                          piece_locked
);
   logic [2:0]       st_q, st_d;
   logic             req_q, req_d;
   cmd_t             cmd_q, cmd_d;
   logic             pend_l_q, pend_l_d, pend_r_q, pend_r_d;
   logic             pend_g_q, pend_g_d, pend_d_q, pend_d_d;
   logic [CNT_W-1:0] g_q, g_d;
   logic             drop_q;
   logic             set_l, set_r, both, drop_set;
   logic             g_run, g_wrap, done, idle_go, ack;
   logic             sel_d, sel_g, sel_l, sel_r;
   piece_move_scheduler_key_autorepeat #(.DAS_DELAY(DAS_DELAY), .DAS_REPEAT(DAS_REPEAT), .CNT_W(CNT_W)) u_left (
      .clk(clk), .rst(rst), .en_i(game_en), .key_i(key_left), .set_o(set_l)
   );
   piece_move_scheduler_key_autorepeat #(.DAS_DELAY(DAS_DELAY), .DAS_REPEAT(DAS_REPEAT), .CNT_W(CNT_W)) u_right (
      .clk(clk), .rst(rst), .en_i(game_en), .key_i(key_right), .set_o(set_r)
   );
   assign both     = key_left & key_right;
   assign drop_set = game_en & key_drop & ~drop_q;
   assign g_run    = game_en & (st_q != ST_DROP);
   assign g_wrap   = g_q == CNT_W'(GRAVITY_TICKS - 1);
   assign done     = st_q == ST_DONE;
   assign idle_go  = (st_q == ST_IDLE) & game_en & (pend_d_q | pend_g_q | pend_l_q | pend_r_q);
   assign ack      = bus.move_ack & req_q;
   assign sel_d    = idle_go & pend_d_q;
   assign sel_g    = idle_go & ~pend_d_q & pend_g_q;
   assign sel_l    = idle_go & ~pend_d_q & ~pend_g_q & pend_l_q;
   assign sel_r    = idle_go & ~pend_d_q & ~pend_g_q & ~pend_l_q & pend_r_q;
   // A new set in the issue cycle wins over the clear: it is a fresh request.
   assign pend_d_d = game_en & ~done & ((pend_d_q & ~sel_d) | drop_set);
   assign pend_g_d = game_en & ~done & ((pend_g_q & ~sel_g) | (g_run & g_wrap));
   assign pend_l_d = game_en & ~done & ~both & ((pend_l_q & ~sel_l) | set_l);
   assign pend_r_d = game_en & ~done & ~both & ((pend_r_q & ~sel_r) | set_r);
   assign g_d      = (~game_en | done) ? '0 : ~g_run ? g_q : g_wrap ? '0 : g_q + CNT_W'(1);
   always_comb begin
      st_d  = st_q;
      req_d = req_q;
      cmd_d = cmd_q;
      case (st_q)
         ST_IDLE: if (idle_go) begin
            st_d  = pend_d_q ? ST_DROP : ST_WAIT;
            req_d = 1'b1;
            cmd_d = (pend_d_q | pend_g_q) ? CMD_DOWN : pend_l_q ? CMD_LEFT : CMD_RIGHT;
         end
         ST_WAIT, ST_DROP: if (ack) begin
            st_d  = ~game_en ? ST_IDLE
                  : (cmd_q == CMD_DOWN && !bus.move_ok) ? ST_LOCK
                  : (st_q == ST_DROP) ? ST_DROP : ST_IDLE;
            req_d = st_d != ST_IDLE;
            cmd_d = (st_d == ST_LOCK) ? CMD_LOCK : cmd_q;
         end
         ST_LOCK: if (ack) begin
            st_d  = ST_DONE;
            req_d = 1'b0;
         end
         default: begin
            st_d  = ST_IDLE;
            req_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= ST_IDLE;
         req_q    <= 1'b0;
         cmd_q    <= CMD_LEFT;
         pend_l_q <= 1'b0;
         pend_r_q <= 1'b0;
         pend_g_q <= 1'b0;
         pend_d_q <= 1'b0;
         g_q      <= '0;
         drop_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         req_q    <= req_d;
         cmd_q    <= cmd_d;
         pend_l_q <= pend_l_d;
         pend_r_q <= pend_r_d;
         pend_g_q <= pend_g_d;
         pend_d_q <= pend_d_d;
         g_q      <= g_d;
         drop_q   <= key_drop;
      end
   end
   assign bus.move_req = req_q;
   assign bus.move_cmd = cmd_q;
   assign piece_locked = done;
endmodule

// File: tb/tb_piece_move_scheduler.sv
// tb_piece_move_scheduler: directed scenarios against a 2-cycle-ack datapath responder
module tb_piece_move_scheduler;
   localparam int L = 0, R = 1, D = 2, K = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic game_en = 1'b0, key_left = 1'b0, key_right = 1'b0, key_drop = 1'b0;
   logic piece_locked;
   int checks = 0, errors = 0, cyc = 0, m = 0, wcnt = 0, stab_err = 0, lock_n = 0, lock_cyc = 0;
   logic prev_req = 1'b0, ack_seen;
   logic [1:0] prev_cmd = 2'd0;
   int log_cmd[$], log_cyc[$];
   bit ok_q[$];
   piece_move_scheduler_if bus();
   piece_move_scheduler #(.GRAVITY_TICKS(16), .DAS_DELAY(8), .DAS_REPEAT(4), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .game_en(game_en), .key_left(key_left), .key_right(key_right),
      .key_drop(key_drop), .bus(bus), .piece_locked(piece_locked)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Datapath model: ack two cycles into each transaction, ok taken from ok_q (default 1).
   initial begin
      bus.move_ack = 1'b0;
      bus.move_ok  = 1'b0;
      forever begin
         @(negedge clk);
         ack_seen = bus.move_ack;
         if (bus.move_req && prev_req && !ack_seen && bus.move_cmd != prev_cmd) stab_err++;
         prev_req = bus.move_req;
         prev_cmd = bus.move_cmd;
         if (piece_locked) begin
            lock_n++;
            lock_cyc = cyc;
         end
         bus.move_ack = 1'b0;
         if (rst || !bus.move_req) wcnt = 0;
         else if (ack_seen || wcnt == 0) begin
            wcnt = 1;
            log_cmd.push_back(int'(bus.move_cmd));
            log_cyc.push_back(cyc);
         end else begin
            wcnt++;
            if (wcnt == 2) begin
               bus.move_ack = 1'b1;
               bus.move_ok  = ok_q.size() > 0 ? ok_q.pop_front() : 1'b1;
            end
         end
      end
   end
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic restart();
      rst = 1'b1;
      game_en = 1'b0;
      key_left = 1'b0;
      key_right = 1'b0;
      key_drop = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      log_cmd.delete();
      log_cyc.delete();
      ok_q.delete();
      lock_n = 0;
      lock_cyc = 0;
      @(negedge clk);
      m = cyc;
   endtask
   task automatic wait_rel(input int n);
      while (cyc < m + n) @(negedge clk);
   endtask
   task automatic expect_seq(input string tag, input int n, input int ec[6], input int et[6]);
      chk({tag, "_count"}, log_cmd.size(), n);
      for (int i = 0; i < n && i < log_cmd.size(); i++) begin
         chk($sformatf("%s_cmd%0d", tag, i), log_cmd[i], ec[i]);
         chk($sformatf("%s_t%0d", tag, i), log_cyc[i] - m, et[i]);
      end
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_req", int'(bus.move_req), 0);
      chk("rst_cmd", int'(bus.move_cmd), 0);
      chk("rst_locked", int'(piece_locked), 0);
      restart();
      game_en = 1'b1;
      wait_rel(55);
      expect_seq("grav", 3, '{D, D, D, 0, 0, 0}, '{17, 33, 49, 0, 0, 0});
      restart();
      game_en = 1'b1;
      key_left = 1'b1;
      wait_rel(20);
      key_left = 1'b0;
      wait_rel(40);
      expect_seq("das", 6, '{L, L, L, D, L, D}, '{2, 10, 14, 17, 20, 33});
      restart();
      game_en = 1'b1;
      key_left = 1'b1;
      key_right = 1'b1;
      wait_rel(40);
      expect_seq("both", 2, '{D, D, 0, 0, 0, 0}, '{17, 33, 0, 0, 0, 0});
      restart();
      game_en = 1'b1;
      wait_rel(15);
      key_left = 1'b1;
      wait_rel(17);
      key_left = 1'b0;
      wait_rel(40);
      expect_seq("prio", 3, '{D, L, D, 0, 0, 0}, '{17, 20, 33, 0, 0, 0});
      restart();
      ok_q = '{1'b1, 1'b1, 1'b1, 1'b0};
      game_en = 1'b1;
      wait_rel(3);
      key_drop = 1'b1;
      wait_rel(5);
      key_drop = 1'b0;
      wait_rel(7);
      key_left = 1'b1;
      wait_rel(9);
      key_left = 1'b0;
      wait_rel(40);
      expect_seq("drop", 6, '{D, D, D, D, K, D}, '{5, 7, 9, 11, 13, 33});
      chk("drop_lock_pulses", lock_n, 1);
      chk("drop_lock_time", lock_cyc - m, 15);
      restart();
      game_en = 1'b1;
      key_left = 1'b1;
      wait_rel(1);
      key_drop = 1'b1;
      wait_rel(2);
      game_en = 1'b0;
      wait_rel(5);
      chk("en_req_low", int'(bus.move_req), 0);
      key_left = 1'b0;
      key_drop = 1'b0;
      wait_rel(20);
      game_en = 1'b1;
      wait_rel(45);
      expect_seq("en", 2, '{L, D, 0, 0, 0, 0}, '{2, 37, 0, 0, 0, 0});
      restart();
      game_en = 1'b1;
      key_right = 1'b1;
      wait_rel(2);
      chk("midrst_req_before", int'(bus.move_req), 1);
      chk("midrst_cmd_before", int'(bus.move_cmd), R);
      rst = 1'b1;
      wait_rel(3);
      chk("midrst_req", int'(bus.move_req), 0);
      chk("midrst_cmd", int'(bus.move_cmd), 0);
      chk("midrst_locked", int'(piece_locked), 0);
      chk("cmd_stable", stab_err, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
